// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes the segment bus across N_LED_AN digits.
// Every digit slot begins with blanking, and new digit data is double-buffered until a frame boundary.
module display_scan_controller #(
  parameter int N_LED = 8,
  parameter int N_LED_AN = 4,
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      load_i,
  input  logic [N_LED*N_LED_AN-1:0] seg_data_i,
  output logic [N_LED-1:0]          led_o,
  output logic [N_LED_AN-1:0]       led_an_o,
  output logic                      pending_o,
  output logic                      frame_o
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int KW = N_LED_AN > 1 ? $clog2(N_LED_AN) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] dig, dig_n;
  logic [N_LED*N_LED_AN-1:0] pend, act;
  logic fstart, last;
  assign last = dig == KW'(N_LED_AN - 1);
  // The slot counter runs through BLANK and SHOW; the state tracks which part of the slot is current.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dig_n = dig;
    fstart = 1'b0;
    if (!enable_i) begin
      state_n = IDLE;
      cnt_n = '0;
      dig_n = '0;
    end else if (state == IDLE) begin
      state_n = BLANK;
      cnt_n = '0;
      dig_n = '0;
      fstart = 1'b1;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      state_n = BLANK;
      cnt_n = '0;
      dig_n = last ? '0 : dig + 1'b1;
      fstart = last;
    end else begin
      cnt_n = cnt + 1'b1;
      state_n = (cnt_n == CW'(BLANK_CYCLES)) ? SHOW : state;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      dig <= '0;
      pend <= '1;
      act <= '1;
      pending_o <= 1'b0;
      frame_o <= 1'b0;
      led_o <= '1;
      led_an_o <= '1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dig <= dig_n;
      frame_o <= fstart;
      if (fstart && pending_o) act <= pend;
      // A load on the commit edge stays pending, so the commit uses the older contents.
      if (load_i) begin
        pend <= seg_data_i;
        pending_o <= 1'b1;
      end else if (fstart) pending_o <= 1'b0;
      led_an_o <= (state_n == SHOW) ? ~(N_LED_AN'(1) << dig_n) : '1;
      led_o <= (state_n == SHOW) ? act[dig_n*N_LED +: N_LED] : '1;
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: scoreboard bench comparing the DUT against a frame/slot arithmetic model.
module tb_display_scan_controller;
  localparam int NL = 8, NA = 4, CD = 8, BC = 2;
  logic clk = 0, rst = 1, en = 0, ld = 0;
  logic [NL*NA-1:0] data = '0;
  logic [NL-1:0] led;
  logic [NA-1:0] an;
  logic pend, frame;
  display_scan_controller #(.N_LED(NL), .N_LED_AN(NA), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .load_i(ld), .seg_data_i(data),
    .led_o(led), .led_an_o(an), .pending_o(pend), .frame_o(frame)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [NL-1:0] led;
    logic [NA-1:0] an;
    logic pend;
    logic frame;
  } exp_t;
  exp_t q[$];
  int checks = 0, passed = 0;
  bit running, pflag;
  int t;
  logic [NL-1:0] act_m[NA], pend_m[NA];
  logic [NA-1:0] prev_an = '1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) prev_an = '1;
    else begin
      chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
      if (prev_an != '1 && an != '1) chk("anode_gap", 32'(an), 32'(prev_an));
      prev_an = an;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("led", 32'(led), 32'(e.led));
      chk("anode", 32'(an), 32'(e.an));
      chk("pending", 32'(pend), 32'(e.pend));
      chk("frame", 32'(frame), 32'(e.frame));
    end
  end
  task automatic model_reset();
    running = 0;
    pflag = 0;
    t = 0;
    for (int k = 0; k < NA; k++) begin
      act_m[k] = '1;
      pend_m[k] = '1;
    end
  endtask
  task automatic step(input bit e_, input bit l_, input logic [NL*NA-1:0] d);
    exp_t x;
    int slot;
    en = e_;
    ld = l_;
    data = d;
    @(posedge clk);
    #1;
    if (!e_) running = 0;
    else if (!running) begin
      running = 1;
      t = 0;
    end else t++;
    x.frame = running && (t % (NA * CD) == 0);
    if (x.frame && pflag) begin
      act_m = pend_m;
      pflag = 0;
    end
    if (l_) begin
      for (int k = 0; k < NA; k++) pend_m[k] = d[k*NL +: NL];
      pflag = 1;
    end
    x.pend = pflag;
    slot = (t / CD) % NA;
    if (running && (t % CD) >= BC) begin
      x.an = ~(NA'(1) << slot);
      x.led = act_m[slot];
    end else begin
      x.an = '1;
      x.led = '1;
    end
    q.push_back(x);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0);
  endtask
  initial begin
    model_reset();
    #12;
    chk("rst_led", 32'(led), 32'hFF);
    chk("rst_anode", 32'(an), 32'hF);
    chk("rst_pending", 32'(pend), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    rst = 0;
    run(70);
    step(1, 1, 32'h0331_3103);
    run(80);
    step(1, 1, 32'h1111_1111);
    run(5);
    step(1, 1, 32'h2222_2222);
    run(70);
    step(1, 1, 32'hAAAA_AAAA);
    while ((t + 1) % (NA * CD) != 0) step(1, 0, '0);
    step(1, 1, 32'h5555_5555);
    run(70);
    while (!((t / CD) % NA == 2 && (t % CD) >= BC + 1)) step(1, 0, '0);
    repeat (3) step(0, 0, '0);
    run(40);
    repeat (500) step($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0, $urandom);
    step(1, 1, 32'h1234_5678);
    run(40);
    step(1, 1, 32'h8765_4321);
    while ((t % CD) < BC + 2) step(1, 0, '0);
    #2;
    rst = 1;
    q.delete();
    #1;
    chk("async_rst_anode", 32'(an), 32'hF);
    chk("async_rst_led", 32'(led), 32'hFF);
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_pending_clear", 32'(pend), 32'd0);
    rst = 0;
    run(40);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Time-multiplexes the shared segment bus across N_LED_AN seven-segment digits on the board display. Each digit slot is a fixed-length scan period with a leading blanking interval that suppresses ghosting. New display contents are double-buffered and committed only at a frame boundary, so a frame never shows a mix of old and new digits. Upstream blocks (parity/word display logic) present segment patterns; this block owns led_o and led_an_o.

Parameters:
N_LED, 8, segments per digit (including dp); segments are active-low
N_LED_AN, 4, number of digits; anodes are active-low
CLK_DIV, 50000, clock cycles per digit slot; must be >= 2
BLANK_CYCLES, 16, leading blank cycles per slot; 1 <= BLANK_CYCLES < CLK_DIV

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
enable_i  input  1  scanning enable; low blanks the display
load_i  input  1  one-cycle strobe; captures seg_data_i
seg_data_i  input  N_LED*N_LED_AN  digit k pattern at bits [k*N_LED +: N_LED]
led_o  output  N_LED  segment bus, active-low
led_an_o  output  N_LED_AN  anode selects, active-low
pending_o  output  1  high while a loaded frame awaits commit
frame_o  output  1  one-cycle pulse at every frame start

Behaviour:
- The clock is clk_i. Reset is rst_i, asynchronous and active-high. All outputs are registered.
- Reset values:
  - led_o all 1s and led_an_o all 1s (display dark).
  - Pending and active buffers all 1s (blank). pending_o=0, frame_o=0.
  - State IDLE, digit index 0, slot counter 0.
- States:
  - IDLE: dark outputs. When enable_i=1, go to BLANK with digit 0. This counts as a frame start.
  - BLANK: led_o all 1s, led_an_o all 1s. Runs for BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW: led_an_o bit k=0 and all other bits 1; led_o = active[k]. Runs for CLK_DIV-BLANK_CYCLES cycles.
    - At the end of SHOW, go to BLANK with k+1.
    - If k=N_LED_AN-1, wrap to k=0. This wrap is a frame start.
- Slot counter: width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 per slot and resets to 0 on each slot change. The BLANK-to-SHOW change happens when the counter reaches BLANK_CYCLES.
- Frame start (entry to BLANK of digit 0):
  - frame_o=1 for exactly that cycle.
  - If pending_o=1, the active buffer takes the pending buffer and pending_o clears, on the same edge.
- load_i=1: the pending buffer takes seg_data_i and pending_o=1 on the next edge.
  - Multiple loads before a commit: last one wins.
  - load_i on the same edge as a frame-start commit: the commit uses the old pending contents. The new data stays pending, pending_o stays 1, and it commits at the next frame start.
- load_i is accepted in every state, including IDLE.
- enable_i=0 in any state:
  - Next edge: state IDLE, outputs dark, counter 0, digit 0.
  - The active and pending buffers are kept.
- Re-enable always starts a fresh frame at digit 0.
- Full scan period = N_LED_AN*CLK_DIV cycles. With the defaults at 100 MHz: 2 ms per frame, 500 Hz refresh.
- Only one anode is ever low at a time. Between two different anodes there are always at least BLANK_CYCLES all-dark cycles.
- Reset mid-slot: outputs go dark immediately (asynchronously), with no glitch to another digit.

Test Plan:
- Bench uses CLK_DIV=8, BLANK_CYCLES=2, N_LED_AN=4.
- Reset then enable_i=1, no load -> frame_o pulses every 32 cycles. led_an_o sequence: 1111 x2, 1110 x6, 1111 x2, 1101 x6, 1111 x2, 1011 x6, 1111 x2, 0111 x6. led_o stays 8'hFF throughout.
- Enabled, load_i with seg_data_i=32'h0331_3103 mid-frame -> pending_o=1 until the next frame_o. From that frame on, digit 0 shows 8'h03, digit 1 8'h31, digit 2 8'h31, digit 3 8'h03. No digit in the current frame changes.
- Two loads (32'h11111111 then 32'h22222222) in one frame -> only 8'h22 patterns appear in the next frame; 8'h11 never appears.
- load_i on the frame-start edge with pending 32'hAAAAAAAA and new data 32'h55555555 -> the next frame shows AA, pending_o stays 1, and the frame after shows 55.
- enable_i=0 while digit 2 is in SHOW -> next cycle led_an_o=1111 and led_o=FF. Re-enable -> frame_o pulses, two blank cycles, then digit 0 shows the retained data.
- rst_i asserted mid-SHOW between clock edges -> outputs go dark before the next edge. After release: pending_o=0 and the first frame is blank.
- Assertion across all runs: led_an_o never has more than one zero bit, and never changes from one zero-anode to a different zero-anode without passing through 1111.
